scratch_load_arbiter: RTL
=========================

Name: scratch_load_arbiter

Overview:
- Shares the single input-buffer read port between NUM_REQ scratchpad loaders (e.g. filter and ifmap scratchpads).
- Each grant moves exactly one word:
  - round-robin arbitration, then a buffer read request held until valid;
  - then a one-cycle write strobe to the granted scratchpad.
- Each requester has its own word counter. `done` pulses once every requester has received BURST_LEN words.

Parameters:
- NUM_REQ, 2, number of scratchpad requesters (2..8)
- DATA_W, 16, buffer word width
- BURST_LEN, 9, words delivered to each requester per load
- CNT_W, 4, per-requester counter width; must satisfy 2^CNT_W > BURST_LEN

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset; clears all state
- inner_rst  in  1  synchronous, active-high soft clear; same effect as rst
- start  in  1  begin a load; sampled only in IDLE
- req  in  NUM_REQ  per-requester "scratchpad can accept a word" (level)
- buf_valid  in  1  buffer has returned data for the current read
- buf_data  in  DATA_W  buffer read data, qualified by buf_valid
- buf_read_req  out  1  read request to the buffer
- grant  out  NUM_REQ  one-hot current owner of the buffer port; 0 when none
- wr_en  out  NUM_REQ  one-hot one-cycle write strobe to a scratchpad
- wr_data  out  DATA_W  registered word for the strobed scratchpad
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the load completes

Behaviour:
- Reset (rst or inner_rst high at a clock edge):
  - state=IDLE, all counters=0, rr_ptr=NUM_REQ-1 so requester 0 wins first;
  - wr_data=0, all outputs 0.
  - Applies mid-operation with no partial write: a pending read is abandoned and buf_read_req drops the next cycle.
- States: IDLE, ARB, READ, WRITE, DONE.
- IDLE:
  - busy=0;
  - start=1 -> ARB; otherwise stay.
- ARB:
  - eligible[i] = req[i] and cnt[i] < BURST_LEN.
  - Pick the first eligible index searching rr_ptr+1, rr_ptr+2, ..., wrapping modulo NUM_REQ; register it as g.
  - Any eligible -> READ; none -> stay in ARB (no timeout); grant=0 while in ARB.
- READ:
  - grant[g]=1 and buf_read_req=1 every cycle.
  - Deasserting req[g] in READ does not revoke the grant.
  - On buf_valid=1: latch buf_data into wr_data, -> WRITE. buf_valid in any other state is ignored.
  - Minimum latency: 1 cycle in READ if buf_valid is already high.
- WRITE (exactly 1 cycle):
  - wr_en[g]=1, grant[g]=1, buf_read_req=0;
  - cnt[g] += 1, rr_ptr <= g.
  - If, after this increment, every cnt equals BURST_LEN -> DONE; else -> ARB.
- DONE (1 cycle):
  - done=1;
  - all counters cleared to 0; rr_ptr retained;
  - -> IDLE.
- start is ignored outside IDLE. start held high continuously re-launches the next load one cycle after DONE.
- Best-case word period is 3 cycles: ARB, READ, WRITE.
- A requester that has reached BURST_LEN is never granted again in that load, even if its req stays high.
- Outputs grant, wr_en, buf_read_req, busy and done are decoded from registered state and g only; they contain no combinational path from inputs.

Decomposition:
- Shared package:
  - state encoding as a 3-bit enumerated type (IDLE=0, ARB=1, READ=2, WRITE=3, DONE=4);
  - default parameter constants.
- One sub-module, rr_pick:
  - purely combinational;
  - inputs eligible[NUM_REQ] and rr_ptr;
  - outputs found and idx;
  - unit-tested separately.

Test Plan:
- NUM_REQ=2, BURST_LEN=3, req=2'b11, buf_valid always 1, start pulse -> grant order 0,1,0,1,0,1; wr_data matches buf_data per word; done pulses once exactly 18 cycles after the first ARB cycle; busy=0 the following cycle.
- req=2'b10 only -> requester 1 receives 3 words; then the arbiter waits in ARB with done=0; raising req[0] -> requester 0 receives 3 words, then done.
- buf_valid delayed 4 cycles in READ -> buf_read_req and grant held steady for 4 cycles; a spurious buf_valid pulse during ARB causes no write.
- req[g] dropped during READ -> transfer still completes to g; cnt[g] increments by 1.
- rst asserted in READ after 2 words delivered -> next cycle state=IDLE, all outputs 0; a new start restarts with requester 0 and all counters at 0; same check repeated with inner_rst.
- start pulsed while busy -> ignored, no extra done pulse; start held high -> second load begins one cycle after DONE, first grant goes to requester 0, the next round-robin index after the previous last requester 1.

Source files
------------

// File: rtl/scratch_load_arbiter_pkg.sv
// scratch_load_arbiter_pkg: shared state encoding and default parameters for the scratchpad load arbiter
package scratch_load_arbiter_pkg;
   localparam int NUM_REQ_DEF = 2;
   localparam int DATA_W_DEF = 16;
   localparam int BURST_LEN_DEF = 9;
   localparam int CNT_W_DEF = 4;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARB   = 3'd1,
      READ  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_e;
endpackage

// File: rtl/scratch_load_arbiter_rr_pick.sv
// scratch_load_arbiter_rr_pick: combinational round-robin pick starting one past rr_ptr
module scratch_load_arbiter_rr_pick
   import scratch_load_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input  logic [NUM_REQ-1:0]         eligible,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic                       found,
   output logic [$clog2(NUM_REQ)-1:0] idx
);
   localparam int PTR_W = $clog2(NUM_REQ);
   // scanning farthest-first lets the nearest eligible index overwrite the rest
   always_comb begin
      found = |eligible;
      idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (eligible[PTR_W'((int'(rr_ptr) + k) % NUM_REQ)]) idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
   end
endmodule

// File: rtl/scratch_load_arbiter.sv
// scratch_load_arbiter: round-robin sharing of one buffer read port among scratchpad loaders,
// one word per grant, with a done pulse once every requester has its full burst
module scratch_load_arbiter
   import scratch_load_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inner_rst,
   input  logic               start,
   input  logic [NUM_REQ-1:0] req,
   input  logic               buf_valid,
   input  logic [DATA_W-1:0]  buf_data,
   output logic               buf_read_req,
   output logic [NUM_REQ-1:0] grant,
   output logic [NUM_REQ-1:0] wr_en,
   output logic [DATA_W-1:0]  wr_data,
   output logic               busy,
   output logic               done
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(BURST_LEN);

   state_e              state_q;
   logic [PTR_W-1:0]    g_q;
   logic [PTR_W-1:0]    rr_ptr_q;
   logic [CNT_W-1:0]    cnt_q [NUM_REQ];
   logic [DATA_W-1:0]   wr_data_q;
   logic [NUM_REQ-1:0]  eligible;
   logic [NUM_REQ-1:0]  g_hot;
   logic [PTR_W-1:0]    idx;
   logic                found;
   logic                all_full;

   scratch_load_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .eligible(eligible),
      .rr_ptr  (rr_ptr_q),
      .found   (found),
      .idx     (idx)
   );

   // all_full looks ahead to the counts after the current WRITE increment
   always_comb begin
      eligible = '0;
      all_full = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req[i] && (cnt_q[i] < FULL);
         all_full &= (((PTR_W'(i) == g_q) ? cnt_q[i] + 1'b1 : cnt_q[i]) == FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || inner_rst) begin
         state_q <= IDLE;
         g_q <= '0;
         rr_ptr_q <= PTR_W'(NUM_REQ - 1);
         wr_data_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) state_q <= ARB;
            ARB: if (found) begin
               g_q <= idx;
               state_q <= READ;
            end
            READ: if (buf_valid) begin
               wr_data_q <= buf_data;
               state_q <= WRITE;
            end
            WRITE: begin
               cnt_q[g_q] <= cnt_q[g_q] + 1'b1;
               rr_ptr_q <= g_q;
               state_q <= all_full ? DONE : ARB;
            end
            DONE: begin
               for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign g_hot = NUM_REQ'(1) << g_q;
   assign grant = (state_q == READ || state_q == WRITE) ? g_hot : '0;
   assign wr_en = (state_q == WRITE) ? g_hot : '0;
   assign buf_read_req = (state_q == READ);
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign wr_data = wr_data_q;
endmodule
